// File: rtl/game_pkg.sv
// Shared types and default screen layout for the pair-matching game.
// The draw path and the flip controller import the same tile geometry.
package game_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ONE_UP  = 5'b00010,
        ST_COMPARE = 5'b00100,
        ST_SHOW    = 5'b01000,
        ST_DONE    = 5'b10000
    } state_t;

    localparam int COORD_W    = 12;
    localparam int DEF_X0     = 100;
    localparam int DEF_Y0     = 100;
    localparam int DEF_TILE_A = 128;
    localparam int DEF_TILE_B = 128;
    localparam int DEF_GAP    = 16;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_hit_decoder.sv
// Maps a screen coordinate to the tile under it (inclusive bounds on all sides).
// Shared by the flip controller and the draw logic so both agree on the layout.
module tile_hit_decoder
    import game_pkg::*;
#(
    parameter int TILE_COLS = 4,
    parameter int TILE_ROWS = 2,
    parameter int X0        = DEF_X0,
    parameter int Y0        = DEF_Y0,
    parameter int TILE_A    = DEF_TILE_A,
    parameter int TILE_B    = DEF_TILE_B,
    parameter int GAP       = DEF_GAP,
    parameter int IDX_W     = idx_w(TILE_COLS * TILE_ROWS)
) (
    input  logic [COORD_W-1:0] xpos_i,
    input  logic [COORD_W-1:0] ypos_i,
    output logic               hit_valid_o,
    output logic [IDX_W-1:0]   hit_idx_o
);

    int   col;
    int   row;
    logic col_hit;
    logic row_hit;

    // NOTE: every variable driven here gets a default first, so no path through the loops can infer a latch.
    always_comb begin
        col     = 0;
        row     = 0;
        col_hit = 1'b0;
        row_hit = 1'b0;
        // GAP >= 1 keeps neighbouring ranges disjoint, so at most one column/row matches.
        for (int c = 0; c < TILE_COLS; c++) begin
            if (int'(xpos_i) >= X0 + c * (TILE_A + GAP) &&
                int'(xpos_i) <= X0 + c * (TILE_A + GAP) + TILE_A) begin
                col_hit = 1'b1;
                col     = c;
            end
        end
        for (int r = 0; r < TILE_ROWS; r++) begin
            if (int'(ypos_i) >= Y0 + r * (TILE_B + GAP) &&
                int'(ypos_i) <= Y0 + r * (TILE_B + GAP) + TILE_B) begin
                row_hit = 1'b1;
                row     = r;
            end
        end
        hit_valid_o = col_hit & row_hit;
        hit_idx_o   = IDX_W'(row * TILE_COLS + col);
    end

endmodule

// File: rtl/card_flip_controller.sv
// Central sequencer for the memory game: turns mouse clicks into tile flips,
// compares each pair, holds a mismatch on screen, then hides it again.
module card_flip_controller
    import game_pkg::*;
#(
    parameter int TILE_COLS   = 4,
    parameter int TILE_ROWS   = 2,
    parameter int ID_W        = 3,
    parameter int X0          = DEF_X0,
    parameter int Y0          = DEF_Y0,
    parameter int TILE_A      = DEF_TILE_A,
    parameter int TILE_B      = DEF_TILE_B,
    parameter int GAP         = DEF_GAP,
    parameter int HOLD_CYCLES = 65_000_000,
    localparam int N          = TILE_COLS * TILE_ROWS,
    localparam int PW         = $clog2(N / 2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MouseLeft,
    input  logic [COORD_W-1:0]   xpos,
    input  logic [COORD_W-1:0]   ypos,
    input  logic                 restart,
    input  logic [N*ID_W-1:0]    card_ids,
    output logic [N-1:0]         face_up,
    output logic [N-1:0]         matched,
    output logic [PW-1:0]        pairs_found,
    output logic                 mismatch,
    output logic                 game_done
);

    localparam int             IW         = idx_w(N);
    localparam int             TW         = idx_w(HOLD_CYCLES);
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0]  ALL_PAIRS  = PW'(N / 2);

    state_t          state_q, state_d;
    logic            ml_q;
    logic [N-1:0]    face_q, face_d;
    logic [N-1:0]    match_q, match_d;
    logic [PW-1:0]   pairs_q, pairs_d;
    logic            mis_q, mis_d;
    logic            done_q, done_d;
    logic [IW-1:0]   first_q, first_d;
    logic [IW-1:0]   second_q, second_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            click;
    logic            pick;
    logic            hit_valid;
    logic [IW-1:0]   hit_idx;
    logic [ID_W-1:0] id_first;
    logic [ID_W-1:0] id_second;

    tile_hit_decoder #(
        .TILE_COLS (TILE_COLS),
        .TILE_ROWS (TILE_ROWS),
        .X0        (X0),
        .Y0        (Y0),
        .TILE_A    (TILE_A),
        .TILE_B    (TILE_B),
        .GAP       (GAP),
        .IDX_W     (IW)
    ) u_hit (
        .xpos_i      (xpos),
        .ypos_i      (ypos),
        .hit_valid_o (hit_valid),
        .hit_idx_o   (hit_idx)
    );

    // Rising edge of the button level: a held button yields one click.
    assign click     = MouseLeft & ~ml_q;
    assign pick      = click & hit_valid & ~face_q[hit_idx] & ~match_q[hit_idx];
    assign id_first  = card_ids[int'(first_q) * ID_W +: ID_W];
    assign id_second = card_ids[int'(second_q) * ID_W +: ID_W];

    always_comb begin
        state_d  = state_q;
        face_d   = face_q;
        match_d  = match_q;
        pairs_d  = pairs_q;
        mis_d    = 1'b0;
        done_d   = done_q;
        first_d  = first_q;
        second_d = second_q;
        timer_d  = timer_q;

        if (restart) begin
            state_d  = ST_IDLE;
            face_d   = '0;
            match_d  = '0;
            pairs_d  = '0;
            done_d   = 1'b0;
            first_d  = '0;
            second_d = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick) begin
                        face_d[hit_idx] = 1'b1;
                        first_d         = hit_idx;
                        state_d         = ST_ONE_UP;
                    end
                end
                ST_ONE_UP: begin
                    if (pick) begin
                        face_d[hit_idx] = 1'b1;
                        second_d        = hit_idx;
                        state_d         = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (id_first == id_second) begin
                        match_d[first_q]  = 1'b1;
                        match_d[second_q] = 1'b1;
                        pairs_d           = pairs_q + 1'b1;
                        if (pairs_d == ALL_PAIRS) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        mis_d   = 1'b1;
                        timer_d = TIMER_LOAD;
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    // Loaded with HOLD_CYCLES-1 so the pair stays up for HOLD_CYCLES cycles here.
                    if (timer_q == '0) begin
                        face_d[first_q]  = 1'b0;
                        face_d[second_q] = 1'b0;
                        state_d          = ST_IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ml_q     <= 1'b0;
            face_q   <= '0;
            match_q  <= '0;
            pairs_q  <= '0;
            mis_q    <= 1'b0;
            done_q   <= 1'b0;
            first_q  <= '0;
            second_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            ml_q     <= MouseLeft;
            face_q   <= face_d;
            match_q  <= match_d;
            pairs_q  <= pairs_d;
            mis_q    <= mis_d;
            done_q   <= done_d;
            first_q  <= first_d;
            second_q <= second_d;
            timer_q  <= timer_d;
        end
    end

    assign face_up     = face_q;
    assign matched     = match_q;
    assign pairs_found = pairs_q;
    assign mismatch    = mis_q;
    assign game_done   = done_q;

endmodule

// File: tb/tb_card_flip_controller.sv
// Directed bench for card_flip_controller on a 2x2 grid with a pick-list
// reference model checked every cycle, plus hand-computed scenario checks.
module tb_card_flip_controller;
    import game_pkg::*;

    localparam int COLS = 2;
    localparam int ROWS = 2;
    localparam int N    = COLS * ROWS;
    localparam int ID_W = 2;
    localparam int A    = 10;
    localparam int B    = 10;
    localparam int G    = 2;
    localparam int HOLD = 4;
    localparam int PW   = $clog2(N / 2 + 1);
    // tile 0 = ID 0, tile 1 = ID 1, tile 2 = ID 0, tile 3 = ID 1
    localparam logic [N*ID_W-1:0] CARD_IDS = 8'b01_00_01_00;

    logic              clk;
    logic              rst;
    logic              MouseLeft;
    logic [11:0]       xpos;
    logic [11:0]       ypos;
    logic              restart;
    logic [N*ID_W-1:0] card_ids;
    logic [N-1:0]      face_up;
    logic [N-1:0]      matched;
    logic [PW-1:0]     pairs_found;
    logic              mismatch;
    logic              game_done;

    int total = 0;
    int bad   = 0;
    int mis_seen = 0;

    card_flip_controller #(
        .TILE_COLS   (COLS),
        .TILE_ROWS   (ROWS),
        .ID_W        (ID_W),
        .X0          (0),
        .Y0          (0),
        .TILE_A      (A),
        .TILE_B      (B),
        .GAP         (G),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MouseLeft   (MouseLeft),
        .xpos        (xpos),
        .ypos        (ypos),
        .restart     (restart),
        .card_ids    (card_ids),
        .face_up     (face_up),
        .matched     (matched),
        .pairs_found (pairs_found),
        .mismatch    (mismatch),
        .game_done   (game_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_face;
    logic [N-1:0] m_match;
    int           m_pairs;
    bit           m_mis;
    bit           m_done;
    bit           m_prev_ml;
    bit           m_cmp;
    int           m_show;
    int           picks[$];
    bit           model_live = 1'b0;

    function automatic int id_of(input int i);
        logic [N*ID_W-1:0] ids;
        ids = CARD_IDS;
        return int'(ids[i*ID_W +: ID_W]);
    endfunction

    function automatic int hit_tile(input int x, input int y);
        int c, r;
        c = x / (A + G);
        r = y / (B + G);
        if (x % (A + G) > A || y % (B + G) > B || c >= COLS || r >= ROWS) return -1;
        return r * COLS + c;
    endfunction

    task automatic model_clear();
        m_face  = '0;
        m_match = '0;
        m_pairs = 0;
        m_mis   = 1'b0;
        m_done  = 1'b0;
        m_cmp   = 1'b0;
        m_show  = 0;
        picks.delete();
    endtask

    task automatic model_step();
        bit click;
        int t;
        if (rst) begin
            model_clear();
            m_prev_ml = 1'b0;
            return;
        end
        click     = MouseLeft && !m_prev_ml;
        m_prev_ml = MouseLeft;
        m_mis     = 1'b0;
        if (restart) begin
            model_clear();
            return;
        end
        if (m_done) return;
        if (m_cmp) begin
            m_cmp = 1'b0;
            if (id_of(picks[0]) == id_of(picks[1])) begin
                m_match[picks[0]] = 1'b1;
                m_match[picks[1]] = 1'b1;
                m_pairs++;
                picks.delete();
                if (m_pairs == N / 2) m_done = 1'b1;
            end else begin
                m_mis  = 1'b1;
                m_show = HOLD;
            end
            return;
        end
        if (m_show > 0) begin
            m_show--;
            if (m_show == 0) begin
                m_face[picks[0]] = 1'b0;
                m_face[picks[1]] = 1'b0;
                picks.delete();
            end
            return;
        end
        if (!click) return;
        t = hit_tile(int'(xpos), int'(ypos));
        if (t < 0) return;
        if (m_face[t] || m_match[t]) return;
        m_face[t] = 1'b1;
        picks.push_back(t);
        if (picks.size() == 2) m_cmp = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            model_live = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("model_face_up", face_up, m_face);
                check("model_matched", matched, m_match);
                check("model_pairs", pairs_found, m_pairs);
                check("model_mismatch", mismatch, m_mis);
                check("model_game_done", game_done, m_done);
            end
            if (mismatch === 1'b1) mis_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input int x, input int y);
        xpos      = 12'(x);
        ypos      = 12'(y);
        MouseLeft = 1'b1;
        @(negedge clk);
        MouseLeft = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int up_cnt;
        int mis_cnt;
        rst       = 1'b1;
        MouseLeft = 1'b0;
        restart   = 1'b0;
        xpos      = '0;
        ypos      = '0;
        card_ids  = CARD_IDS;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_face_up", face_up, 4'b0000);
        check("reset_done", game_done, 1'b0);
        check("reset_state", dut.state_q, ST_IDLE);

        // Match: tile 0 then tile 2 (both ID 0)
        mis_seen = 0;
        press(5, 5);
        press(5, 17);
        @(negedge clk);
        check("match_face_up", face_up, 4'b0101);
        check("match_matched", matched, 4'b0101);
        check("match_pairs", pairs_found, 2'd1);
        check("match_state", dut.state_q, ST_IDLE);
        check("match_no_mismatch", mis_seen, 0);

        // Mismatch timing: tile 0 then tile 1
        pulse_restart();
        press(5, 5);
        xpos      = 12'd17;
        ypos      = 12'd5;
        MouseLeft = 1'b1;
        @(negedge clk);
        MouseLeft = 1'b0;
        check("mm_compare_face", face_up, 4'b0011);
        check("mm_compare_pulse", mismatch, 1'b0);
        @(negedge clk);
        up_cnt  = 0;
        mis_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (face_up == 4'b0011) up_cnt++;
            if (mismatch) mis_cnt++;
            @(negedge clk);
        end
        check("mm_visible_cycles", up_cnt, HOLD);
        check("mm_pulse_cycles", mis_cnt, 1);
        check("mm_hidden", face_up, 4'b0000);
        check("mm_state", dut.state_q, ST_IDLE);

        // Ignored clicks
        pulse_restart();
        press(11, 5);
        check("gap_face_up", face_up, 4'b0000);
        check("gap_state", dut.state_q, ST_IDLE);
        press(5, 5);
        press(5, 5);
        check("reclick_face_up", face_up, 4'b0001);
        check("reclick_state", dut.state_q, ST_ONE_UP);
        press(17, 5);
        press(17, 17);
        check("show_click_face", face_up, 4'b0011);
        check("show_click_state", dut.state_q, ST_SHOW);
        repeat (4) @(negedge clk);
        check("show_end_face", face_up, 4'b0000);
        xpos      = 12'd5;
        ypos      = 12'd5;
        MouseLeft = 1'b1;
        repeat (50) @(negedge clk);
        xpos = 12'd17;
        repeat (50) @(negedge clk);
        MouseLeft = 1'b0;
        @(negedge clk);
        check("hold_face_up", face_up, 4'b0001);
        check("hold_state", dut.state_q, ST_ONE_UP);

        // Completion
        pulse_restart();
        press(5, 5);
        press(5, 17);
        press(17, 5);
        press(17, 17);
        @(negedge clk);
        check("done_pairs", pairs_found, 2'd2);
        check("done_flag", game_done, 1'b1);
        check("done_matched", matched, 4'b1111);
        press(5, 5);
        press(17, 17);
        check("done_hold_face", face_up, 4'b1111);
        check("done_hold_state", dut.state_q, ST_DONE);

        // Restart from DONE
        pulse_restart();
        check("restart_face", face_up, 4'b0000);
        check("restart_matched", matched, 4'b0000);
        check("restart_pairs", pairs_found, 2'd0);
        check("restart_done", game_done, 1'b0);
        check("restart_state", dut.state_q, ST_IDLE);

        // Reset in the middle of SHOW with the button held through it
        press(5, 5);
        press(17, 5);
        check("pre_rst_state", dut.state_q, ST_SHOW);
        xpos      = 12'd5;
        ypos      = 12'd17;
        MouseLeft = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_face", face_up, 4'b0000);
        check("rst_mismatch", mismatch, 1'b0);
        check("rst_ml_q", dut.ml_q, 1'b0);
        check("rst_state", dut.state_q, ST_IDLE);
        @(negedge clk);
        check("rst_held_click", face_up, 4'b0100);
        repeat (5) @(negedge clk);
        check("rst_held_once", dut.state_q, ST_ONE_UP);
        MouseLeft = 1'b0;
        @(negedge clk);

        // Inclusive tile boundaries
        pulse_restart();
        press(0, 0);
        check("bound_0_0", face_up, 4'b0001);
        pulse_restart();
        press(10, 10);
        check("bound_10_10", face_up, 4'b0001);
        pulse_restart();
        press(12, 0);
        check("bound_12_0", face_up, 4'b0010);
        pulse_restart();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
